fp12_accum: RTL and testbench



---
 rtl/fp12_accum_if.sv | 24 ++
 rtl/fp12_accum.sv | 190 +++++++++++++++++++
 tb/tb_fp12_accum.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp12_accum_if.sv
// rtl/fp12_accum_if.sv - product stream in, group sum out, for the FP12 accumulator
interface fp12_accum_if #(
    parameter int CNT_W = 8
);
    logic [11:0]      in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [11:0]      sum;
    logic [CNT_W-1:0] sum_count;
    logic             sum_valid;
    logic             sum_ready;
    logic             ovf;

    modport master (
        output in_data, in_valid, in_last, sum_ready,
        input  in_ready, sum, sum_count, sum_valid, ovf
    );

    modport slave (
        input  in_data, in_valid, in_last, sum_ready,
        output in_ready, sum, sum_count, sum_valid, ovf
    );
endinterface

// File: rtl/fp12_accum.sv
// rtl/fp12_accum.sv - FP12 group accumulator; FP12_ACC_SAT_EN selects clamp-on-overflow instead of infinity
module fp12_accum #(
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    fp12_accum_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;

`ifdef FP12_ACC_SAT_EN
    localparam logic [10:0] OVF_MAG = 11'h7BF;
`else
    localparam logic [10:0] OVF_MAG = 11'h7C0;
`endif

    state_t           state, state_nxt;
    logic [11:0]      acc, cap_data;
    logic             cap_last;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             accept;

    // Aligned operands and special-case result held between stages
    logic [9:0]       ma_r, mb_r;
    logic             sa_r, sb_r;
    logic [4:0]       e_r;
    logic             spec_r;
    logic [11:0]      spec_val_r;
    logic [10:0]      mag_r;
    logic             sign_r;

    logic [4:0]       ea, eb, ediff;
    logic [9:0]       ma_raw, mb_raw, m_small, m_shift;
    logic             a_big, acc_stuck;

    assign ea      = acc[10:6];
    assign eb      = cap_data[10:6];
    assign ma_raw  = (ea == 5'd0) ? 10'd0 : {1'b1, acc[5:0], 3'b000};
    assign mb_raw  = (eb == 5'd0) ? 10'd0 : {1'b1, cap_data[5:0], 3'b000};
    assign a_big   = (ea >= eb);
    assign ediff   = a_big ? (ea - eb) : (eb - ea);
    assign m_small = a_big ? mb_raw : ma_raw;
    assign m_shift = (ediff >= 5'd10) ? 10'd0 : (m_small >> ediff);

`ifdef FP12_ACC_SAT_EN
    assign acc_stuck = 1'b0;
`else
    // An infinite accumulator absorbs every later product of the group
    assign acc_stuck = (ea == 5'd31);
`endif

    assign accept        = bus.in_valid && (state == IDLE) && !rst;
    assign bus.sum       = acc;
    assign bus.sum_count = count;
    assign bus.ovf       = ovf;

    logic [10:0] add_mag;
    logic        add_sign;

    // Signed-magnitude add: larger magnitude sets the sign on subtraction
    always_comb begin
        add_mag  = 11'd0;
        add_sign = sa_r;
        if (sa_r == sb_r) begin
            add_mag = {1'b0, ma_r} + {1'b0, mb_r};
        end else if (ma_r >= mb_r) begin
            add_mag = {1'b0, ma_r - mb_r};
        end else begin
            add_mag  = {1'b0, mb_r - ma_r};
            add_sign = sb_r;
        end
    end

    logic [3:0]        lead, shamt;
    logic [5:0]        norm_frac;
    logic signed [6:0] norm_e;
    logic [11:0]       norm_res;
    logic              norm_ovf;

    // Leading-one normalize with truncation, flushing underflow to +0
    always_comb begin
        lead = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (mag_r[i]) lead = 4'(i);
        end
        shamt = 4'd9 - lead;
        if (mag_r[10]) begin
            norm_frac = mag_r[9:4];
            norm_e    = $signed({2'b00, e_r}) + 7'sd1;
        end else begin
            norm_frac = 6'((mag_r[9:0] << shamt) >> 3);
            norm_e    = $signed({2'b00, e_r}) - $signed({3'b000, shamt});
        end
        norm_ovf = 1'b0;
        if (spec_r) begin
            norm_res = spec_val_r;
            norm_ovf = 1'b1;
        end else if (mag_r == 11'd0 || norm_e <= 7'sd0) begin
            norm_res = 12'h000;
        end else if (norm_e >= 7'sd31) begin
            norm_res = {sign_r, OVF_MAG};
            norm_ovf = 1'b1;
        end else begin
            norm_res = {sign_r, norm_e[4:0], norm_frac};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.sum_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = !rst;
                if (accept) state_nxt = ALIGN;
            end
            ALIGN: state_nxt = ADD;
            ADD:   state_nxt = NORM;
            NORM:  state_nxt = cap_last ? OUT : IDLE;
            OUT: begin
                bus.sum_valid = 1'b1;
                if (bus.sum_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture, align, add, normalize, and group clear
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= 12'h000;
            cap_data   <= 12'h000;
            cap_last   <= 1'b0;
            count      <= '0;
            ovf        <= 1'b0;
            ma_r       <= 10'd0;
            mb_r       <= 10'd0;
            sa_r       <= 1'b0;
            sb_r       <= 1'b0;
            e_r        <= 5'd0;
            spec_r     <= 1'b0;
            spec_val_r <= 12'h000;
            mag_r      <= 11'd0;
            sign_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_data <= bus.in_data;
                        cap_last <= bus.in_last;
                        if (count != '1) count <= count + 1'b1;
                    end
                end
                ALIGN: begin
                    ma_r       <= a_big ? ma_raw : m_shift;
                    mb_r       <= a_big ? m_shift : mb_raw;
                    sa_r       <= acc[11];
                    sb_r       <= cap_data[11];
                    e_r        <= a_big ? ea : eb;
                    spec_r     <= acc_stuck || (eb == 5'd31);
                    spec_val_r <= acc_stuck ? acc : {cap_data[11], OVF_MAG};
                end
                ADD: begin
                    mag_r  <= add_mag;
                    sign_r <= add_sign;
                end
                NORM: begin
                    acc <= norm_res;
                    if (norm_ovf) ovf <= 1'b1;
                end
                OUT: begin
                    if (bus.sum_ready) begin
                        acc   <= 12'h000;
                        count <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp12_accum.sv
// tb/tb_fp12_accum.sv - directed and randomized checks of fp12_accum against an arithmetic model
module tb_fp12_accum;
    localparam int CNT_W = 8;
`ifdef FP12_ACC_SAT_EN
    localparam logic [10:0] OVF_MAG = 11'h7BF;
`else
    localparam logic [10:0] OVF_MAG = 11'h7C0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          failures = 0;
    logic [11:0] grp[$];

    fp12_accum_if #(.CNT_W(CNT_W)) bus();
    fp12_accum #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Value model: operand = +-m * 2^(e-24) with m the 10-bit mantissa; returns {ovf, result}
    function automatic logic [12:0] ref_add(input logic [11:0] a, input logic [11:0] p);
        int ea, ep, ma, mp, big_e, s, mag, n, e, m7;
        logic sgn;
        ea = int'(a[10:6]);
        ep = int'(p[10:6]);
`ifndef FP12_ACC_SAT_EN
        if (ea == 31) return {1'b1, a};
`endif
        if (ep == 31) return {1'b1, p[11], OVF_MAG};
        ma = (ea == 0) ? 0 : (64 + int'(a[5:0])) * 8;
        mp = (ep == 0) ? 0 : (64 + int'(p[5:0])) * 8;
        big_e = (ea > ep) ? ea : ep;
        ma = (big_e - ea >= 10) ? 0 : ma / (2 ** (big_e - ea));
        mp = (big_e - ep >= 10) ? 0 : mp / (2 ** (big_e - ep));
        s = (a[11] ? -ma : ma) + (p[11] ? -mp : mp);
        if (s == 0) return 13'h0000;
        sgn = (s < 0);
        mag = sgn ? -s : s;
        n = 0;
        while ((2 ** (n + 1)) <= mag) n++;
        e = big_e + n - 9;
        m7 = (n >= 6) ? mag / (2 ** (n - 6)) : mag * (2 ** (6 - n));
        if (e <= 0) return 13'h0000;
        if (e >= 31) return {1'b1, sgn, OVF_MAG};
        return {1'b0, sgn, 5'(e), 6'(m7)};
    endfunction

    function automatic logic [11:0] rand_fp12();
        int sel;
        logic [4:0] ex;
        sel = $urandom_range(0, 15);
        if (sel == 0)      ex = 5'd0;
        else if (sel == 1) ex = 5'd31;
        else if (sel == 2) ex = 5'($urandom_range(29, 30));
        else if (sel == 3) ex = 5'($urandom_range(1, 3));
        else               ex = 5'($urandom_range(12, 18));
        return {1'($urandom_range(0, 1)), ex, 6'($urandom_range(0, 63))};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [11:0] d, input logic last, output bit ok);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            step(1);
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_timeout in_ready=%b want=1", bus.in_ready);
            ok = 1'b0;
            return;
        end
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        step(1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        ok = 1'b1;
    endtask

    // Called one #1 after the accept edge of the group's last product
    task automatic finish_group(input string name, input logic [11:0] exp_sum,
                                input logic [CNT_W-1:0] exp_cnt, input logic exp_ovf);
        step(2);
        checks++;
        if (bus.sum_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s early_valid got=%b want=0", name, bus.sum_valid);
        end
        step(1);
        checks++;
        if (bus.sum_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s sum_valid got=%b want=1", name, bus.sum_valid);
        end
        checks++;
        if (bus.sum !== exp_sum) begin
            failures++;
            $display("FAIL %s sum got=%h want=%h", name, bus.sum, exp_sum);
        end
        checks++;
        if (bus.sum_count !== exp_cnt) begin
            failures++;
            $display("FAIL %s count got=%0d want=%0d", name, bus.sum_count, exp_cnt);
        end
        checks++;
        if (bus.ovf !== exp_ovf) begin
            failures++;
            $display("FAIL %s ovf got=%b want=%b", name, bus.ovf, exp_ovf);
        end
        bus.sum_ready = 1'b1;
        step(1);
        bus.sum_ready = 1'b0;
        checks++;
        if (bus.sum_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sum !== 12'h000 ||
            bus.sum_count !== '0 || bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL %s cleared valid=%b ready=%b sum=%h cnt=%0d ovf=%b want 0/1/000/0/0",
                     name, bus.sum_valid, bus.in_ready, bus.sum, bus.sum_count, bus.ovf);
        end
    endtask

    task automatic run_group(input string name, input logic [11:0] exp_sum,
                             input logic [CNT_W-1:0] exp_cnt, input logic exp_ovf);
        bit ok;
        for (int i = 0; i < grp.size(); i++) begin
            send(grp[i], (i == grp.size() - 1), ok);
            if (!ok) return;
        end
        finish_group(name, exp_sum, exp_cnt, exp_ovf);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.in_data = 12'h000;
        bus.sum_ready = 1'b0;
        step(3);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.sum !== 12'h000 || bus.sum_count !== '0 ||
            bus.sum_valid !== 1'b0 || bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_values ready=%b sum=%h cnt=%0d valid=%b ovf=%b want 0/000/0/0/0",
                     bus.in_ready, bus.sum, bus.sum_count, bus.sum_valid, bus.ovf);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release in_ready got=%b want=1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        bit ok;
        send(12'h3E0, 1'b0, ok);
        step(2);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy in_ready got=%b want=0", bus.in_ready);
        end
        step(1);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_ready_again in_ready got=%b want=1", bus.in_ready);
        end
        send(12'h400, 1'b1, ok);
        finish_group("basic", 12'h430, 8'd2, 1'b0);
    endtask

    task automatic test_directed();
        grp = '{12'h3E0, 12'hBE0};
        run_group("cancel", 12'h000, 8'd2, 1'b0);
        grp = '{12'h3E0, 12'h0C0};
        run_group("align_loss", 12'h3E0, 8'd2, 1'b0);
        grp = '{12'h7BF, 12'h7BF};
        run_group("overflow", {1'b0, OVF_MAG}, 8'd2, 1'b1);
        grp = '{12'h7BF, 12'h7BF, 12'hBE0};
        run_group("ovf_sticky", {1'b0, OVF_MAG}, 8'd3, 1'b1);
        grp = '{12'hFC0};
        run_group("inf_input", {1'b1, OVF_MAG}, 8'd1, 1'b1);
        grp = '{12'h03F};
        run_group("zero_exp_single", 12'h000, 8'd1, 1'b0);
    endtask

    task automatic test_backpressure();
        bit ok;
        send(12'h3E0, 1'b0, ok);
        send(12'h400, 1'b1, ok);
        step(3);
        bus.in_data  = 12'h3E0;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++;
            if (bus.sum !== 12'h430 || bus.in_ready !== 1'b0 || bus.sum_count !== 8'd2 ||
                bus.sum_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold%0d sum=%h ready=%b cnt=%0d valid=%b want 430/0/2/1",
                         i, bus.sum, bus.in_ready, bus.sum_count, bus.sum_valid);
            end
        end
        bus.sum_ready = 1'b1;
        step(1);
        bus.sum_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.sum_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_handshake ready=%b valid=%b want 1/0", bus.in_ready, bus.sum_valid);
        end
        step(1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        finish_group("bp_next", 12'h3E0, 8'd1, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int seen;
        send(12'h3E0, 1'b0, ok);
        send(12'h400, 1'b0, ok);
        step(1);
        rst = 1'b1;
        step(1);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.sum !== 12'h000 || bus.sum_count !== '0 ||
            bus.sum_valid !== 1'b0 || bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset ready=%b sum=%h cnt=%0d valid=%b ovf=%b want 0/000/0/0/0",
                     bus.in_ready, bus.sum, bus.sum_count, bus.sum_valid, bus.ovf);
        end
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (bus.sum_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL mid_reset_no_valid cycles_valid=%0d want=0", seen);
        end
        grp = '{12'h400};
        run_group("after_reset", 12'h400, 8'd1, 1'b0);
    endtask

    task automatic test_count_sat();
        grp.delete();
        for (int i = 0; i < 260; i++) grp.push_back(12'h000);
        run_group("count_sat", 12'h000, 8'd255, 1'b0);
    endtask

    task automatic test_random();
        logic [11:0] acc;
        logic [12:0] r;
        logic        o;
        int          len;
        for (int g = 0; g < 40; g++) begin
            len = $urandom_range(1, 4);
            acc = 12'h000;
            o = 1'b0;
            grp.delete();
            for (int k = 0; k < len; k++) begin
                grp.push_back(rand_fp12());
                r = ref_add(acc, grp[k]);
                acc = r[11:0];
                o = o | r[12];
            end
            run_group($sformatf("rand%0d", g), acc, 8'(len), o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_count_sat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
